// File: rtl/game_flow_ctrl.sv
// Game-level screen sequencer: splash -> play -> dying -> game-over, with
// BCD survival timer, best-time tracking and engine restart pulse.
module game_flow_ctrl #(
  parameter int unsigned CLK_HZ            = 100_000_000,
  parameter int unsigned SPLASH_CYCLES     = 500_000_000,
  parameter int unsigned OVER_DELAY_CYCLES = 5_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        f_tick,
  input  logic        game_over,
  input  logic        start_btn,
  output logic        game_begin,
  output logic        game_over_display,
  output logic [1:0]  bam_sel,
  output logic        cloud_en,
  output logic        engine_rst,
  output logic [15:0] score_bcd,
  output logic [15:0] best_bcd
);

  localparam logic [31:0] SPLASH_LAST = 32'(SPLASH_CYCLES - 1);
  localparam logic [31:0] OVER_LAST   = 32'(OVER_DELAY_CYCLES - 1);
  localparam logic [31:0] SEC_LAST    = 32'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_SPLASH = 2'd0,
    ST_PLAY   = 2'd1,
    ST_DYING  = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_timer;
  logic [31:0] w_timer_next;
  logic [31:0] r_presc;
  logic [31:0] w_presc_next;
  logic        r_armed;
  logic        w_armed_next;
  logic [15:0] r_score;
  logic [15:0] w_score_next;
  logic [15:0] r_best;
  logic [15:0] w_best_next;

  logic        r_btn_meta;
  logic        r_btn_sync;
  logic        r_btn_prev;
  logic        w_start_edge;

  logic        r_game_begin;
  logic        r_over_disp;
  logic [1:0]  r_bam_sel;
  logic        r_cloud_en;
  logic        r_engine_rst;
  logic        w_game_begin_next;
  logic        w_over_disp_next;
  logic [1:0]  w_bam_sel_next;
  logic        w_cloud_en_next;
  logic        w_engine_rst_next;
  logic        w_enter_play;

  // BCD +1 with ripple carry across digits; holds at 9999.
  logic [4:0]  w_carry;
  logic [15:0] w_score_inc_raw;
  logic [15:0] w_score_inc;

  assign w_carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd_digit
      logic w_nine;
      assign w_nine = (r_score[gi*4 +: 4] == 4'd9);
      assign w_carry[gi+1] = w_carry[gi] & w_nine;
      assign w_score_inc_raw[gi*4 +: 4] =
        !w_carry[gi] ? r_score[gi*4 +: 4] :
        w_nine       ? 4'd0 :
                       r_score[gi*4 +: 4] + 4'd1;
    end
  endgenerate

  assign w_score_inc  = w_carry[4] ? r_score : w_score_inc_raw;
  assign w_start_edge = r_btn_sync & ~r_btn_prev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= start_btn;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_presc_next = r_presc;
    w_armed_next = r_armed;
    w_score_next = r_score;
    w_best_next  = r_best;
    w_enter_play = 1'b0;

    case (r_state)
      ST_SPLASH: begin
        if (w_start_edge || (r_timer == SPLASH_LAST)) begin
          w_enter_play = 1'b1;
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      ST_PLAY: begin
        // A death in the same cycle as a second boundary freezes the score first.
        if (r_armed && game_over) begin
          w_state_next = ST_DYING;
          w_timer_next = 32'd0;
        end else begin
          if (r_presc == SEC_LAST) begin
            w_presc_next = 32'd0;
            w_score_next = w_score_inc;
          end else begin
            w_presc_next = r_presc + 32'd1;
          end
          if (f_tick) begin
            w_armed_next = 1'b1;
          end
        end
      end
      ST_DYING: begin
        if (r_timer == OVER_LAST) begin
          w_state_next = ST_OVER;
          if (r_score > r_best) begin
            w_best_next = r_score;
          end
        end else begin
          w_timer_next = r_timer + 32'd1;
        end
      end
      ST_OVER: begin
        if (w_start_edge) begin
          w_enter_play = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_SPLASH;
        w_timer_next = 32'd0;
      end
    endcase

    if (w_enter_play) begin
      w_state_next = ST_PLAY;
      w_timer_next = 32'd0;
      w_presc_next = 32'd0;
      w_armed_next = 1'b0;
      w_score_next = 16'h0000;
    end

    w_engine_rst_next = w_enter_play;
    w_game_begin_next = (w_state_next != ST_SPLASH);
    w_over_disp_next  = (w_state_next == ST_OVER);
    w_cloud_en_next   = (w_state_next == ST_PLAY) || (w_state_next == ST_DYING);
    case (w_state_next)
      ST_SPLASH: w_bam_sel_next = 2'd0;
      ST_OVER:   w_bam_sel_next = 2'd2;
      default:   w_bam_sel_next = 2'd1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= ST_SPLASH;
      r_timer      <= 32'd0;
      r_presc      <= 32'd0;
      r_armed      <= 1'b0;
      r_score      <= 16'h0000;
      r_best       <= 16'h0000;
      r_game_begin <= 1'b0;
      r_over_disp  <= 1'b0;
      r_bam_sel    <= 2'd0;
      r_cloud_en   <= 1'b0;
      r_engine_rst <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_presc      <= w_presc_next;
      r_armed      <= w_armed_next;
      r_score      <= w_score_next;
      r_best       <= w_best_next;
      r_game_begin <= w_game_begin_next;
      r_over_disp  <= w_over_disp_next;
      r_bam_sel    <= w_bam_sel_next;
      r_cloud_en   <= w_cloud_en_next;
      r_engine_rst <= w_engine_rst_next;
    end
  end

  assign game_begin        = r_game_begin;
  assign game_over_display = r_over_disp;
  assign bam_sel           = r_bam_sel;
  assign cloud_en          = r_cloud_en;
  assign engine_rst        = r_engine_rst;
  assign score_bcd         = r_score;
  assign best_bcd          = r_best;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random stimulus against
// a phase-level reference model; a second instance checks score saturation.
module tb_game_flow_ctrl;

  localparam int HZ  = 10;
  localparam int SPL = 20;
  localparam int DLY = 5;

  localparam int P_SPLASH = 0;
  localparam int P_PLAY   = 1;
  localparam int P_DYING  = 2;
  localparam int P_OVER   = 3;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        f_tick = 1'b0;
  logic        game_over = 1'b0;
  logic        start_btn = 1'b0;
  logic        game_begin;
  logic        game_over_display;
  logic [1:0]  bam_sel;
  logic        cloud_en;
  logic        engine_rst;
  logic [15:0] score_bcd;
  logic [15:0] best_bcd;

  logic        sat_clr = 1'b1;
  logic        sat_game_begin;
  logic        sat_over_disp;
  logic [1:0]  sat_bam_sel;
  logic        sat_cloud_en;
  logic        sat_engine_rst;
  logic [15:0] sat_score;
  logic [15:0] sat_best;

  always #5 clk = ~clk;

  game_flow_ctrl #(.CLK_HZ(HZ), .SPLASH_CYCLES(SPL), .OVER_DELAY_CYCLES(DLY)) dut (
    .clk(clk), .clr(clr), .f_tick(f_tick), .game_over(game_over), .start_btn(start_btn),
    .game_begin(game_begin), .game_over_display(game_over_display), .bam_sel(bam_sel),
    .cloud_en(cloud_en), .engine_rst(engine_rst), .score_bcd(score_bcd), .best_bcd(best_bcd)
  );

  game_flow_ctrl #(.CLK_HZ(1), .SPLASH_CYCLES(2), .OVER_DELAY_CYCLES(3)) u_sat (
    .clk(clk), .clr(sat_clr), .f_tick(1'b0), .game_over(1'b0), .start_btn(1'b0),
    .game_begin(sat_game_begin), .game_over_display(sat_over_disp), .bam_sel(sat_bam_sel),
    .cloud_en(sat_cloud_en), .engine_rst(sat_engine_rst), .score_bcd(sat_score), .best_bcd(sat_best)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: phase, seconds survived as a plain integer, best as max.
  int m_phase, m_elapsed, m_play_n, m_score, m_best;
  bit m_armed, m_rst_pulse, h1, h2, h3;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_phase = P_SPLASH; m_elapsed = 0; m_play_n = 0; m_score = 0; m_best = 0;
    m_armed = 0; m_rst_pulse = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic enter_play();
    m_phase = P_PLAY; m_play_n = 0; m_score = 0; m_armed = 0; m_rst_pulse = 1;
  endtask

  task automatic model_edge(input bit ft, input bit go, input bit btn);
    bit start;
    start = h2 & !h3;
    h3 = h2; h2 = h1; h1 = btn;
    m_rst_pulse = 0;
    case (m_phase)
      P_SPLASH: if (start || m_elapsed == SPL - 1) enter_play(); else m_elapsed++;
      P_PLAY: begin
        if (m_armed && go) begin
          m_phase = P_DYING; m_elapsed = 0;
        end else begin
          m_play_n++;
          m_score = (m_play_n / HZ > 9999) ? 9999 : m_play_n / HZ;
          if (ft) m_armed = 1;
        end
      end
      P_DYING: begin
        if (m_elapsed == DLY - 1) begin
          m_phase = P_OVER;
          if (m_score > m_best) m_best = m_score;
        end else m_elapsed++;
      end
      default: if (start) enter_play();
    endcase
  endtask

  task automatic compare_all();
    check("bam_sel", 32'(bam_sel), (m_phase == P_SPLASH) ? 0 : (m_phase == P_OVER) ? 2 : 1);
    check("game_begin", 32'(game_begin), 32'(m_phase != P_SPLASH));
    check("cloud_en", 32'(cloud_en), 32'(m_phase == P_PLAY || m_phase == P_DYING));
    check("game_over_display", 32'(game_over_display), 32'(m_phase == P_OVER));
    check("engine_rst", 32'(engine_rst), 32'(m_rst_pulse));
    check("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    check("best_bcd", 32'(best_bcd), 32'(to_bcd(m_best)));
  endtask

  // Drive one clock's worth of inputs at a falling edge, then compare.
  task automatic cycle(input bit ft, input bit go, input bit btn);
    f_tick = ft; game_over = go; start_btn = btn;
    model_edge(ft, go, btn);
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2 clr = 1'b1;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    clr = 1'b0;
  endtask

  int pulses;
  bit r_go, r_btn;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    clr = 1'b0;

    $display("scenario 1: splash auto-start");
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      cycle(0, 0, 0);
      pulses += int'(engine_rst);
      check("t1_splash_bam", 32'(bam_sel), 0);
    end
    cycle(0, 0, 0);
    pulses += int'(engine_rst);
    check("t1_play_bam", 32'(bam_sel), 1);
    check("t1_play_begin", 32'(game_begin), 1);
    check("t1_play_cloud", 32'(cloud_en), 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      pulses += int'(engine_rst);
    end
    check("t1_rst_pulses", 32'(pulses), 1);

    $display("scenario 2: start button during splash");
    async_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(0, 0, c >= 5);
      if (c == 6) check("t2_still_splash", 32'(bam_sel), 0);
      if (c == 7) begin
        check("t2_play_bam", 32'(bam_sel), 1);
        check("t2_play_rst", 32'(engine_rst), 1);
      end
    end

    $display("scenario 3: 12 s survival then death");
    cycle(1, 0, 0);
    for (int i = 0; i < 124; i++) cycle(0, 0, 0);
    check("t3_score", 32'(score_bcd), 32'h0012);
    cycle(0, 1, 0);
    check("t3_dying_bam", 32'(bam_sel), 1);
    cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      check("t3_dying_hold", 32'(bam_sel), 1);
    end
    cycle(0, 0, 0);
    check("t3_over_bam", 32'(bam_sel), 2);
    check("t3_over_disp", 32'(game_over_display), 1);
    check("t3_best", 32'(best_bcd), 32'h0012);
    check("t3_score_frozen", 32'(score_bcd), 32'h0012);

    $display("scenario 4: restart with stale game_over");
    cycle(0, 0, 1);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check("t4_rst", 32'(engine_rst), 1);
    check("t4_score_clr", 32'(score_bcd), 0);
    for (int i = 0; i < 49; i++) cycle(0, 1, 0);
    check("t4_not_dying", 32'(bam_sel), 1);
    check("t4_no_over", 32'(game_over_display), 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    check("t4_score5", 32'(score_bcd), 32'h0005);
    check("t4_best_kept", 32'(best_bcd), 32'h0012);

    $display("scenario 5: BCD carry 0099 -> 0100");
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 989; i++) cycle(0, 0, 0);
    check("t5_0099", 32'(score_bcd), 32'h0099);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("t5_0100", 32'(score_bcd), 32'h0100);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);

    $display("scenario 6: async clear mid-dying");
    async_reset();
    check("t6_bam", 32'(bam_sel), 0);
    check("t6_best", 32'(best_bcd), 0);
    check("t6_score", 32'(score_bcd), 0);
    check("t6_begin", 32'(game_begin), 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      pulses += int'(engine_rst);
    end
    check("t6_no_rst", 32'(pulses), 0);

    $display("scenario 7: random stimulus");
    r_go = 0; r_btn = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) r_go = !r_go;
      if ($urandom_range(5) == 0) r_btn = !r_btn;
      if ($urandom_range(1499) == 0) async_reset();
      else cycle($urandom_range(7) == 0, r_go, r_btn);
    end

    $display("scenario 8: score saturation at 9999");
    sat_clr = 1'b0;
    for (int n = 1; n <= 10010; n++) begin
      @(negedge clk);
      if (n >= 2) check("sat_score", 32'(sat_score), 32'(to_bcd((n - 2 > 9999) ? 9999 : n - 2)));
    end
    check("sat_bam", 32'(sat_bam_sel), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
